// File: rtl/mem_dram_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory controller:
// access size encodings and the controller state encoding.
package mem_dram_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        DRAM_IDLE,
        DRAM_REQ,
        DRAM_RESP,
        DRAM_HOLD,
        DRAM_DRAIN
    } dram_state_e;

endpackage

// File: rtl/mem_dram_ctrl_if.sv
// SRAM-like data bus between the MEM-stage controller (master)
// and the data memory (slave).
interface mem_dram_ctrl_if;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_size,
        output data_sram_wstrb,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_addr_ok,
        input  data_sram_data_ok,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_size,
        input  data_sram_wstrb,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_addr_ok,
        output data_sram_data_ok,
        output data_sram_rdata
    );

endinterface

// File: rtl/mem_dram_ctrl_wlane.sv
// Store lane steering: byte strobes from size/offset and
// store data replicated across the lanes it may land on.
module dram_wlane
    import mem_dram_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = i_wdata;
        case (i_size)
            SZ_B: begin
                o_wstrb = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_wstrb = 4'b0011 << i_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            SZ_W: begin
                o_wstrb = 4'b1111;
            end
            default: begin
                o_wstrb = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_dram_ctrl.sv
// MEM-stage data access controller: issues loads/stores on the data
// bus, holds MEM until the response, and drains the bus on flush.
module mem_dram_ctrl
    import mem_dram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_dram_req,
    input  logic              mem_dram_we,
    input  logic [1:0]        mem_dram_size,
    input  logic [31:0]       mem_data_addr,
    input  logic [31:0]       mem_dram_wdata,
    input  logic              mem_ex,
    input  logic              mem_flush,
    input  logic              wb_allowin,
    mem_dram_ctrl_if.master   bus,
    output logic              mem_ready_go,
    output logic [31:0]       mem_dram_rdata
);

    dram_state_e r_state;
    logic        r_flush_seen;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_issue;
    logic [3:0]  w_lane_strb;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    assign w_issue = (r_state == DRAM_IDLE) && mem_valid && mem_dram_req
                     && !mem_ex && !mem_flush;

    dram_wlane u_wlane (
        .i_size  (mem_dram_size),
        .i_off   (mem_data_addr[1:0]),
        .i_wdata (mem_dram_wdata),
        .o_wstrb (w_lane_strb),
        .o_wdata (w_wdata)
    );

    assign w_wstrb = mem_dram_we ? w_lane_strb : 4'b0000;

    // Live inputs drive the bus in the issue cycle, captured copies after.
    always_comb begin
        bus.data_sram_req   = w_issue || (r_state == DRAM_REQ);
        bus.data_sram_wr    = 1'b0;
        bus.data_sram_size  = 2'd0;
        bus.data_sram_wstrb = 4'b0000;
        bus.data_sram_addr  = 32'd0;
        bus.data_sram_wdata = 32'd0;
        if (w_issue) begin
            bus.data_sram_wr    = mem_dram_we;
            bus.data_sram_size  = mem_dram_size;
            bus.data_sram_wstrb = w_wstrb;
            bus.data_sram_addr  = mem_data_addr;
            bus.data_sram_wdata = w_wdata;
        end else if (r_state == DRAM_REQ) begin
            bus.data_sram_wr    = r_wr;
            bus.data_sram_size  = r_size;
            bus.data_sram_wstrb = r_wstrb;
            bus.data_sram_addr  = r_addr;
            bus.data_sram_wdata = r_wdata;
        end
    end

    always_comb begin
        mem_ready_go   = 1'b0;
        mem_dram_rdata = 32'd0;
        unique case (r_state)
            DRAM_IDLE: begin
                mem_ready_go = mem_valid && (!mem_dram_req || mem_ex);
            end
            DRAM_RESP: begin
                mem_ready_go = bus.data_sram_data_ok && !mem_flush;
                if (mem_ready_go) mem_dram_rdata = bus.data_sram_rdata;
            end
            DRAM_HOLD: begin
                mem_ready_go   = 1'b1;
                mem_dram_rdata = r_rdata;
            end
            default: begin
                mem_ready_go = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= DRAM_IDLE;
            r_flush_seen <= 1'b0;
            r_wr         <= 1'b0;
            r_size       <= 2'd0;
            r_wstrb      <= 4'b0000;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_rdata      <= 32'd0;
        end else begin
            unique case (r_state)
                DRAM_IDLE: begin
                    if (w_issue) begin
                        r_wr    <= mem_dram_we;
                        r_size  <= mem_dram_size;
                        r_wstrb <= w_wstrb;
                        r_addr  <= mem_data_addr;
                        r_wdata <= w_wdata;
                        r_state <= bus.data_sram_addr_ok ? DRAM_RESP
                                                         : DRAM_REQ;
                    end
                end
                DRAM_REQ: begin
                    if (mem_flush) r_flush_seen <= 1'b1;
                    if (bus.data_sram_addr_ok) begin
                        r_state <= (r_flush_seen || mem_flush) ? DRAM_DRAIN
                                                               : DRAM_RESP;
                    end
                end
                DRAM_RESP: begin
                    if (bus.data_sram_data_ok) begin
                        if (mem_flush || wb_allowin) begin
                            r_state      <= DRAM_IDLE;
                            r_flush_seen <= 1'b0;
                        end else begin
                            r_rdata <= bus.data_sram_rdata;
                            r_state <= DRAM_HOLD;
                        end
                    end else if (mem_flush) begin
                        r_state <= DRAM_DRAIN;
                    end
                end
                DRAM_HOLD: begin
                    if (mem_flush || wb_allowin) begin
                        r_state      <= DRAM_IDLE;
                        r_flush_seen <= 1'b0;
                    end
                end
                DRAM_DRAIN: begin
                    if (bus.data_sram_data_ok) begin
                        r_state      <= DRAM_IDLE;
                        r_flush_seen <= 1'b0;
                    end
                end
                default: begin
                    r_state <= DRAM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dram_ctrl.sv
// Directed bench for mem_dram_ctrl: inputs change just after the
// falling edge, outputs are checked 1ns later, state moves on the rise.
module tb_mem_dram_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_dram_req;
    logic        mem_dram_we;
    logic [1:0]  mem_dram_size;
    logic [31:0] mem_data_addr;
    logic [31:0] mem_dram_wdata;
    logic        mem_ex;
    logic        mem_flush;
    logic        wb_allowin;
    logic        mem_ready_go;
    logic [31:0] mem_dram_rdata;

    int n_chk;
    int n_fail;

    mem_dram_ctrl_if bus ();

    mem_dram_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_dram_req   (mem_dram_req),
        .mem_dram_we    (mem_dram_we),
        .mem_dram_size  (mem_dram_size),
        .mem_data_addr  (mem_data_addr),
        .mem_dram_wdata (mem_dram_wdata),
        .mem_ex         (mem_ex),
        .mem_flush      (mem_flush),
        .wb_allowin     (wb_allowin),
        .bus            (bus),
        .mem_ready_go   (mem_ready_go),
        .mem_dram_rdata (mem_dram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic op(input logic v, input logic rq, input logic we,
                      input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd);
        mem_valid      = v;
        mem_dram_req   = rq;
        mem_dram_we    = we;
        mem_dram_size  = sz;
        mem_data_addr  = a;
        mem_dram_wdata = wd;
    endtask

    task automatic bus_in(input logic aok, input logic dok,
                          input logic [31:0] rd);
        bus.data_sram_addr_ok = aok;
        bus.data_sram_data_ok = dok;
        bus.data_sram_rdata   = rd;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        mem_ex = 1'b0;
        mem_flush = 1'b0;
        wb_allowin = 1'b1;
        op(0, 0, 0, 2'd0, 32'd0, 32'd0);
        bus_in(0, 0, 32'd0);

        // reset state
        cyc(); #1;
        chk("rst_req", {31'd0, bus.data_sram_req}, 32'd0);
        chk("rst_wr", {31'd0, bus.data_sram_wr}, 32'd0);
        chk("rst_wstrb", {28'd0, bus.data_sram_wstrb}, 32'd0);
        chk("rst_addr", bus.data_sram_addr, 32'd0);
        chk("rst_wdata", bus.data_sram_wdata, 32'd0);
        chk("rst_size", {30'd0, bus.data_sram_size}, 32'd0);
        chk("rst_rgo", {31'd0, mem_ready_go}, 32'd0);
        chk("rst_rdata", mem_dram_rdata, 32'd0);
        cyc(); rst = 1'b0;

        // word load, addr_ok at issue, data_ok next cycle
        cyc(); op(1, 1, 0, 2'd2, 32'h1000, 32'd0); bus_in(1, 0, 32'd0); #1;
        chk("ld_req", {31'd0, bus.data_sram_req}, 32'd1);
        chk("ld_addr", bus.data_sram_addr, 32'h1000);
        chk("ld_wstrb", {28'd0, bus.data_sram_wstrb}, 32'd0);
        chk("ld_wr", {31'd0, bus.data_sram_wr}, 32'd0);
        chk("ld_size", {30'd0, bus.data_sram_size}, 32'd2);
        chk("ld_rgo0", {31'd0, mem_ready_go}, 32'd0);
        cyc(); bus_in(0, 1, 32'hDEADBEEF); #1;
        chk("ld_req1", {31'd0, bus.data_sram_req}, 32'd0);
        chk("ld_rgo1", {31'd0, mem_ready_go}, 32'd1);
        chk("ld_rdata", mem_dram_rdata, 32'hDEADBEEF);
        cyc(); op(1, 0, 0, 2'd0, 32'd0, 32'd0); bus_in(0, 0, 32'd0); #1;
        chk("ld_idle_rgo", {31'd0, mem_ready_go}, 32'd1);
        chk("ld_idle_rdata", mem_dram_rdata, 32'd0);
        chk("ld_idle_req", {31'd0, bus.data_sram_req}, 32'd0);

        // byte store at offset 3
        cyc(); op(1, 1, 1, 2'd0, 32'h1003, 32'h000000A5); bus_in(1, 0, 0); #1;
        chk("sb_wstrb", {28'd0, bus.data_sram_wstrb}, 32'h8);
        chk("sb_wdata", bus.data_sram_wdata, 32'hA5A5A5A5);
        chk("sb_wr", {31'd0, bus.data_sram_wr}, 32'd1);
        chk("sb_addr", bus.data_sram_addr, 32'h1003);
        cyc(); bus_in(0, 1, 32'd0); #1;
        chk("sb_rgo", {31'd0, mem_ready_go}, 32'd1);

        // word store, all lanes
        cyc(); op(1, 1, 1, 2'd2, 32'h2000, 32'h11223344); bus_in(1, 0, 0); #1;
        chk("sw_wstrb", {28'd0, bus.data_sram_wstrb}, 32'hF);
        chk("sw_wdata", bus.data_sram_wdata, 32'h11223344);
        cyc(); bus_in(0, 1, 32'd0); #1;
        chk("sw_rgo", {31'd0, mem_ready_go}, 32'd1);

        // half store at offset 2, addr_ok delayed 3 cycles
        cyc(); op(1, 1, 1, 2'd1, 32'h3002, 32'h0000BEEF); bus_in(0, 0, 0); #1;
        chk("sh_req0", {31'd0, bus.data_sram_req}, 32'd1);
        chk("sh_wstrb0", {28'd0, bus.data_sram_wstrb}, 32'hC);
        chk("sh_wdata0", bus.data_sram_wdata, 32'hBEEFBEEF);
        cyc(); op(1, 1, 1, 2'd0, 32'hFFFFFFF0, 32'h0); #1;
        chk("sh_req1", {31'd0, bus.data_sram_req}, 32'd1);
        chk("sh_addr1", bus.data_sram_addr, 32'h3002);
        chk("sh_wdata1", bus.data_sram_wdata, 32'hBEEFBEEF);
        cyc(); #1;
        chk("sh_req2", {31'd0, bus.data_sram_req}, 32'd1);
        chk("sh_wstrb2", {28'd0, bus.data_sram_wstrb}, 32'hC);
        chk("sh_size2", {30'd0, bus.data_sram_size}, 32'd1);
        cyc(); bus_in(1, 0, 0); #1;
        chk("sh_req3", {31'd0, bus.data_sram_req}, 32'd1);
        chk("sh_addr3", bus.data_sram_addr, 32'h3002);
        chk("sh_wdata3", bus.data_sram_wdata, 32'hBEEFBEEF);
        cyc(); bus_in(0, 1, 0); #1;
        chk("sh_req4", {31'd0, bus.data_sram_req}, 32'd0);
        chk("sh_rgo4", {31'd0, mem_ready_go}, 32'd1);

        // flush while waiting for addr_ok: drain, then a clean load
        cyc(); op(1, 1, 0, 2'd2, 32'h3000, 32'd0); bus_in(0, 0, 0); #1;
        chk("fl_req0", {31'd0, bus.data_sram_req}, 32'd1);
        cyc(); mem_flush = 1'b1; #1;
        chk("fl_req1", {31'd0, bus.data_sram_req}, 32'd1);
        chk("fl_rgo1", {31'd0, mem_ready_go}, 32'd0);
        cyc(); mem_flush = 1'b0; op(0, 0, 0, 2'd0, 0, 0); bus_in(1, 0, 0); #1;
        chk("fl_req2", {31'd0, bus.data_sram_req}, 32'd1);
        chk("fl_rgo2", {31'd0, mem_ready_go}, 32'd0);
        cyc(); bus_in(0, 0, 0); #1;
        chk("fl_req3", {31'd0, bus.data_sram_req}, 32'd0);
        chk("fl_rgo3", {31'd0, mem_ready_go}, 32'd0);
        cyc(); bus_in(0, 1, 32'h55555555); #1;
        chk("fl_rgo4", {31'd0, mem_ready_go}, 32'd0);
        chk("fl_rdata4", mem_dram_rdata, 32'd0);
        cyc(); op(1, 1, 0, 2'd2, 32'h4000, 0); bus_in(1, 0, 0); #1;
        chk("fl_next_req", {31'd0, bus.data_sram_req}, 32'd1);
        chk("fl_next_addr", bus.data_sram_addr, 32'h4000);
        cyc(); bus_in(0, 1, 32'h12345678); #1;
        chk("fl_next_rgo", {31'd0, mem_ready_go}, 32'd1);
        chk("fl_next_rdata", mem_dram_rdata, 32'h12345678);

        // WB stalled: response held until wb_allowin
        cyc(); op(1, 1, 0, 2'd2, 32'h5000, 0); bus_in(1, 0, 0); #1;
        chk("hd_req0", {31'd0, bus.data_sram_req}, 32'd1);
        cyc(); wb_allowin = 1'b0; bus_in(0, 1, 32'hCAFEF00D); #1;
        chk("hd_rgo1", {31'd0, mem_ready_go}, 32'd1);
        chk("hd_rdata1", mem_dram_rdata, 32'hCAFEF00D);
        cyc(); bus_in(0, 0, 32'h0); #1;
        chk("hd_rgo2", {31'd0, mem_ready_go}, 32'd1);
        chk("hd_rdata2", mem_dram_rdata, 32'hCAFEF00D);
        chk("hd_req2", {31'd0, bus.data_sram_req}, 32'd0);
        cyc(); #1;
        chk("hd_rgo3", {31'd0, mem_ready_go}, 32'd1);
        chk("hd_rdata3", mem_dram_rdata, 32'hCAFEF00D);
        cyc(); wb_allowin = 1'b1; #1;
        chk("hd_rgo4", {31'd0, mem_ready_go}, 32'd1);
        chk("hd_rdata4", mem_dram_rdata, 32'hCAFEF00D);
        cyc(); op(0, 0, 0, 2'd0, 0, 0); #1;
        chk("hd_rgo5", {31'd0, mem_ready_go}, 32'd0);
        chk("hd_rdata5", mem_dram_rdata, 32'd0);

        // excepted load never reaches the bus
        cyc(); op(1, 1, 0, 2'd2, 32'h6000, 0); mem_ex = 1'b1; #1;
        chk("ex_req0", {31'd0, bus.data_sram_req}, 32'd0);
        chk("ex_rgo0", {31'd0, mem_ready_go}, 32'd1);
        cyc(); #1;
        chk("ex_req1", {31'd0, bus.data_sram_req}, 32'd0);
        chk("ex_rgo1", {31'd0, mem_ready_go}, 32'd1);
        cyc(); mem_ex = 1'b0; op(0, 0, 0, 2'd0, 0, 0); #1;
        chk("ex_rgo2", {31'd0, mem_ready_go}, 32'd0);

        // flush coinciding with data_ok: data dropped, back to IDLE
        cyc(); op(1, 1, 0, 2'd2, 32'h7000, 0); bus_in(1, 0, 0); #1;
        chk("fd_req0", {31'd0, bus.data_sram_req}, 32'd1);
        cyc(); mem_flush = 1'b1; bus_in(0, 1, 32'h77777777); #1;
        chk("fd_rgo1", {31'd0, mem_ready_go}, 32'd0);
        chk("fd_rdata1", mem_dram_rdata, 32'd0);
        cyc(); mem_flush = 1'b0; op(1, 1, 0, 2'd2, 32'h7100, 0);
        bus_in(1, 0, 0); #1;
        chk("fd_req2", {31'd0, bus.data_sram_req}, 32'd1);
        chk("fd_addr2", bus.data_sram_addr, 32'h7100);
        cyc(); bus_in(0, 1, 32'h71717171); #1;
        chk("fd_rgo3", {31'd0, mem_ready_go}, 32'd1);
        chk("fd_rdata3", mem_dram_rdata, 32'h71717171);

        // flush in RESP before data_ok: drained response is dropped
        cyc(); op(1, 1, 0, 2'd2, 32'h8000, 0); bus_in(1, 0, 0); #1;
        chk("fr_req0", {31'd0, bus.data_sram_req}, 32'd1);
        cyc(); mem_flush = 1'b1; op(0, 0, 0, 2'd0, 0, 0); bus_in(0, 0, 0); #1;
        chk("fr_rgo1", {31'd0, mem_ready_go}, 32'd0);
        cyc(); mem_flush = 1'b0; bus_in(0, 1, 32'h88888888); #1;
        chk("fr_rgo2", {31'd0, mem_ready_go}, 32'd0);
        chk("fr_rdata2", mem_dram_rdata, 32'd0);
        cyc(); op(1, 1, 0, 2'd2, 32'h8100, 0); bus_in(0, 0, 0); #1;
        chk("fr_req3", {31'd0, bus.data_sram_req}, 32'd1);

        // asynchronous reset while waiting in REQ
        cyc(); #1;
        chk("ar_req0", {31'd0, bus.data_sram_req}, 32'd1);
        op(0, 0, 0, 2'd0, 0, 0); rst = 1'b1; #1;
        chk("ar_req1", {31'd0, bus.data_sram_req}, 32'd0);
        chk("ar_addr1", bus.data_sram_addr, 32'd0);
        chk("ar_rgo1", {31'd0, mem_ready_go}, 32'd0);
        cyc(); rst = 1'b0;
        cyc(); op(1, 1, 0, 2'd2, 32'h9000, 0); bus_in(1, 0, 0); #1;
        chk("ar_req2", {31'd0, bus.data_sram_req}, 32'd1);
        chk("ar_addr2", bus.data_sram_addr, 32'h9000);
        cyc(); bus_in(0, 1, 32'h90909090); #1;
        chk("ar_rgo3", {31'd0, mem_ready_go}, 32'd1);
        chk("ar_rdata3", mem_dram_rdata, 32'h90909090);
        cyc(); op(0, 0, 0, 2'd0, 0, 0); bus_in(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
